// File: rtl/axi_mem_slave.sv
// AXI4 burst slave backed by a single-port block RAM; serves one INCR burst at a time.
// Optional macro AXI_MEM_RANGE_CHECK_EN flags bursts that start above the RAM range (SLVERR, no write).
module axi_mem_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 28,
    parameter int C_MEM_WORDS_LOG2 = 11
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int DEPTH = 1 << C_MEM_WORDS_LOG2;
    localparam int NB    = C_AXI_DATA_WIDTH / 8;
    localparam logic [C_MEM_WORDS_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [C_MEM_WORDS_LOG2-1:0] idx_q, idx_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        last_wr_q, last_wr_d;

    logic                        grant_rd, grant_wr;
    logic                        ar_err, aw_err;
    logic                        mem_we, mem_re;
    logic                        rvalid;
    logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;
    logic                        addr_unused;

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign ar_err = |S_AXI_ARADDR[C_OFFSET_WIDTH-1:C_MEM_WORDS_LOG2+2];
    assign aw_err = |S_AXI_AWADDR[C_OFFSET_WIDTH-1:C_MEM_WORDS_LOG2+2];
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // Byte-lane bits, aliased upper bits and WLAST carry no meaning here.
    assign addr_unused = ^{S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_WLAST};

    // Round robin: on a tie the channel that did not win last time is granted.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == IDLE) begin
            if (S_AXI_ARVALID && (!S_AXI_AWVALID || last_wr_q)) begin
                grant_rd = 1'b1;
            end else if (S_AXI_AWVALID) begin
                grant_wr = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    idx_d     = S_AXI_ARADDR[C_MEM_WORDS_LOG2+1:2];
                    cnt_d     = S_AXI_ARLEN;
                    err_d     = ar_err;
                    last_wr_d = 1'b0;
                    state_d   = RD_ADDR;
                end else if (grant_wr) begin
                    idx_d     = S_AXI_AWADDR[C_MEM_WORDS_LOG2+1:2];
                    cnt_d     = S_AXI_AWLEN;
                    err_d     = aw_err;
                    last_wr_d = 1'b1;
                    state_d   = WR_DATA;
                end
            end
            RD_ADDR: begin
                mem_re  = !RST;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_DATA: begin
                if (S_AXI_WVALID) begin
                    mem_we = !err_q && !RST;
                    idx_d  = idx_q + IDX_ONE;
                    if (cnt_q == 8'd0) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Single port: reads happen only in RD_ADDR and writes only in WR_DATA.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we && S_AXI_WSTRB[b]) begin
                mem[idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (mem_re) begin
            ram_rdata <= mem[idx_q];
        end
    end

    assign rvalid        = (state_q == RD_DATA);
    assign S_AXI_ARREADY = grant_rd;
    assign S_AXI_AWREADY = grant_wr;
    assign S_AXI_WREADY  = (state_q == WR_DATA);
    assign S_AXI_BVALID  = (state_q == WR_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && err_q) ? 2'b10 : 2'b00;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = (rvalid && !err_q) ? ram_rdata : '0;
    assign S_AXI_RRESP   = (rvalid && err_q) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST   = rvalid && (cnt_q == 8'd0);

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: byte-level memory model, R/B expectation queues, final report.
module tb_axi_mem_slave;

    localparam int OW    = 28;
    localparam int MW    = 11;
    localparam int DEPTH = 1 << MW;
`ifdef AXI_MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHK_EN = 1'b1;
`else
    localparam bit RANGE_CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [OW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [OW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [34:0]   exp_q[$];
    logic [1:0]    exp_b_q[$];
    logic [31:0]   model_mem [DEPTH];
    logic [31:0]   wdata_buf [256];
    logic [3:0]    wstrb_buf [256];

    axi_mem_slave dut (
        .CLK           (clk),
        .RST           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic range_err(input logic [OW-1:0] a);
        return RANGE_CHK_EN && (a[OW-1:MW+2] != '0);
    endfunction

    // ---------------- model / scoreboard ----------------
    task automatic model_write(input logic [OW-1:0] addr, input logic [7:0] len);
        logic [MW-1:0] idx;
        logic          err;
        idx = addr[MW+1:2];
        err = range_err(addr);
        for (int i = 0; i <= int'(len); i++) begin
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_buf[i][b]) model_mem[idx][8*b +: 8] = wdata_buf[i][8*b +: 8];
                end
            end
            idx++;
        end
        exp_b_q.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic push_read_exp(input logic [OW-1:0] addr, input logic [7:0] len);
        logic [MW-1:0] idx;
        logic          err;
        idx = addr[MW+1:2];
        err = range_err(addr);
        for (int i = 0; i <= int'(len); i++) begin
            if (err) exp_q.push_back({2'b10, i == int'(len), 32'h0});
            else     exp_q.push_back({2'b00, i == int'(len), model_mem[idx]});
            idx++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic ar_handshake(input logic [OW-1:0] addr, input logic [7:0] len);
        int   cyc = 0;
        logic ok = 1'b0;
        araddr  = addr;
        arlen   = len;
        arvalid = 1'b1;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        check_eq("ar_handshake", ok, 1'b1);
    endtask

    task automatic aw_handshake(input logic [OW-1:0] addr, input logic [7:0] len);
        int   cyc = 0;
        logic ok = 1'b0;
        awaddr  = addr;
        awlen   = len;
        awvalid = 1'b1;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = awready;
            tick();
            cyc++;
        end
        awvalid = 1'b0;
        check_eq("aw_handshake", ok, 1'b1);
    endtask

    // mode 0: RREADY held high, 1: toggles every cycle, 2: random
    task automatic collect_read(input int nbeats, input int mode, input bit chk_timing);
        int          got = 0;
        int          cyc = 0;
        int          first_cyc = -1;
        int          last_cyc = -1;
        logic        stall = 1'b0;
        logic [31:0] held = '0;
        logic [34:0] exp;
        rready = 1'b1;
        while (got < nbeats && cyc < nbeats * 20 + 20) begin
            @(negedge clk);
            if (stall) begin
                check_eq("rvalid_held", rvalid, 1'b1);
                check_eq("rdata_stable", rdata, held);
                stall = 1'b0;
            end
            if (rvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check_eq("r_beat", {rresp, rlast, rdata}, exp);
                    if (chk_timing && last_cyc >= 0) check_eq("r_beat_spacing", cyc - last_cyc, 2);
                    last_cyc = cyc;
                    got++;
                end else begin
                    held  = rdata;
                    stall = 1'b1;
                end
            end
            tick();
            cyc++;
            if (mode == 1) rready = ~rready;
            else if (mode == 2) rready = 1'($urandom_range(0, 1));
        end
        rready = 1'b0;
        check_eq("r_beat_count", got, nbeats);
        if (chk_timing) check_eq("r_first_latency", first_cyc, 1);
    endtask

    task automatic w_phase(input logic [7:0] len);
        int          cyc;
        logic        ok;
        logic [1:0]  exp_b;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wdata_buf[i];
            wstrb  = wstrb_buf[i];
            wlast  = (i == int'(len));
            wvalid = 1'b1;
            ok = 1'b0;
            cyc = 0;
            while (!ok && cyc < 50) begin
                @(negedge clk);
                check_eq("bvalid_early", bvalid, 1'b0);
                ok = wready;
                tick();
                cyc++;
            end
            check_eq("w_handshake", ok, 1'b1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            if (bvalid) begin
                ok = 1'b1;
                exp_b = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 'x;
                check_eq("bresp", bresp, exp_b);
                check_eq("b_latency", cyc, 0);
            end
            tick();
            cyc++;
        end
        bready = 1'b0;
        check_eq("b_handshake", ok, 1'b1);
    endtask

    task automatic write_burst(input logic [OW-1:0] addr, input logic [7:0] len);
        model_write(addr, len);
        aw_handshake(addr, len);
        w_phase(len);
    endtask

    task automatic read_burst(input logic [OW-1:0] addr, input logic [7:0] len,
                              input int mode, input bit chk_timing);
        push_read_exp(addr, len);
        ar_handshake(addr, len);
        collect_read(int'(len) + 1, mode, chk_timing);
    endtask

    task automatic fill_buf(input logic [31:0] base, input int n, input logic [3:0] strb);
        for (int i = 0; i < n; i++) begin
            wdata_buf[i] = base + 32'(i);
            wstrb_buf[i] = strb;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_arready", arready, 1'b0);
        check_eq("rst_awready", awready, 1'b0);
        check_eq("rst_wready", wready, 1'b0);
        check_eq("rst_rvalid", rvalid, 1'b0);
        check_eq("rst_bvalid", bvalid, 1'b0);
        check_eq("rst_rlast", rlast, 1'b0);
        check_eq("rst_outs", {rdata, rresp, bresp}, 36'h0);
        tick();

        // preload word i = i, then an 8-beat read from 0x40
        fill_buf(32'h0, 64, 4'hF);
        write_burst(28'h0, 8'd63);
        read_burst(28'h40, 8'd7, 0, 1'b1);

        // 4-beat write and readback
        fill_buf(32'hA0, 4, 4'hF);
        write_burst(28'h100, 8'd3);
        read_burst(28'h100, 8'd3, 0, 1'b1);

        // partial strobe over an existing word
        fill_buf(32'h12345678, 1, 4'hF);
        write_burst(28'h48C, 8'd0);
        fill_buf(32'hDEADBEEF, 1, 4'h3);
        write_burst(28'h48C, 8'd0);
        read_burst(28'h48C, 8'd0, 0, 1'b0);

        // zero strobe consumes a beat without writing
        fill_buf(32'hFFFFFFFF, 2, 4'h0);
        write_burst(28'h40, 8'd1);
        read_burst(28'h40, 8'd1, 0, 1'b0);

        // back-pressure on R
        read_burst(28'h100, 8'd3, 1, 1'b0);
        read_burst(28'h0, 8'd15, 2, 1'b0);

        // index wraps from the top word to word 0
        fill_buf(32'h55AA0001, 2, 4'hF);
        write_burst(28'h1FFC, 8'd1);
        read_burst(28'h1FFC, 8'd1, 0, 1'b0);

        // out-of-range start: SLVERR with the macro, aliasing without it
        read_burst(28'h2000, 8'd1, 0, 1'b0);
        fill_buf(32'h0BAD0BAD, 1, 4'hF);
        write_burst(28'h2004, 8'd0);
        read_burst(28'h4, 8'd0, 0, 1'b0);

        // reset during a read burst: no response may follow
        ar_handshake(28'h40, 8'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rvalid || bvalid) busy++;
            tick();
        end
        check_eq("no_resp_after_reset", busy, 0);

        // simultaneous AR/AW right after reset: read first, then write
        fill_buf(32'hCAFE0001, 1, 4'hF);
        model_write(28'h140, 8'd0);
        push_read_exp(28'h40, 8'd0);
        araddr  = 28'h40;
        arlen   = 8'd0;
        awaddr  = 28'h140;
        awlen   = 8'd0;
        arvalid = 1'b1;
        awvalid = 1'b1;
        @(negedge clk);
        check_eq("arb1_arready", arready, 1'b1);
        check_eq("arb1_awready", awready, 1'b0);
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        check_eq("aw_pending_ready", awready, 1'b0);
        tick();
        collect_read(1, 0, 1'b0);
        araddr  = 28'h140;
        arvalid = 1'b1;
        @(negedge clk);
        check_eq("arb2_awready", awready, 1'b1);
        check_eq("arb2_arready", arready, 1'b0);
        tick();
        awvalid = 1'b0;
        w_phase(8'd0);
        push_read_exp(28'h140, 8'd0);
        ar_handshake(28'h140, 8'd0);
        collect_read(1, 0, 1'b0);

        check_eq("exp_q_drained", exp_q.size(), 0);
        check_eq("exp_b_q_drained", exp_b_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
